// File: rtl/spa_pkg.sv
// spa_pkg: shared types and helpers for the spectrum peak analyzer
package spa_pkg;

    typedef enum logic {
        IDLE,
        COLLECT
    } spa_state_e;

    // Bin index width for a given point count
    function automatic int spa_idx_w(input int n_bins);
        return $clog2(n_bins);
    endfunction

    // Squared-magnitude width: two DATA_W-bit squares summed without overflow
    function automatic int spa_mag_w(input int data_w);
        return 2 * data_w + 1;
    endfunction

    // A bin takes part in the peak search unless it is DC (when excluded)
    // or lies in the mirrored upper half (in half-spectrum mode)
    function automatic logic spa_eligible(input int idx, input int n_bins,
                                          input int skip_dc, input int half);
        return !(skip_dc != 0 && idx == 0) && !(half != 0 && idx >= n_bins / 2);
    endfunction

endpackage

// File: rtl/spa_mag_pipe.sv
// spa_mag_pipe: two-stage squared-magnitude pipe (square, then sum) with index/eligible sideband
module spa_mag_pipe #(
    parameter int DATA_W = 16,
    parameter int IDX_W  = 4,
    parameter int MAG_W  = 2 * DATA_W + 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_i,
    input  logic                     flush_i,
    input  logic                     elig_i,
    input  logic signed [DATA_W-1:0] re_i,
    input  logic signed [DATA_W-1:0] im_i,
    input  logic [IDX_W-1:0]         idx_i,
    output logic                     valid_o,
    output logic                     elig_o,
    output logic [IDX_W-1:0]         idx_o,
    output logic [MAG_W-1:0]         mag_o
);
    localparam int PW = 2 * DATA_W;

    logic signed [PW-1:0] re_x, im_x, re_sq_q, im_sq_q;
    logic                 valid_q, elig_q;
    logic [IDX_W-1:0]     idx_q;

    assign re_x = PW'(re_i);
    assign im_x = PW'(im_i);

    // Stage 1: register both signed squares together with the beat's sideband
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            elig_q  <= 1'b0;
            idx_q   <= '0;
            re_sq_q <= '0;
            im_sq_q <= '0;
        end else begin
            valid_q <= valid_i && !flush_i;
            elig_q  <= elig_i;
            idx_q   <= idx_i;
            re_sq_q <= re_x * re_x;
            im_sq_q <= im_x * im_x;
        end
    end

    // Stage 2: squares are non-negative, so a zero-extended add cannot overflow;
    // a flush kills the entry still in flight
    assign valid_o = valid_q && !flush_i;
    assign elig_o  = elig_q;
    assign idx_o   = idx_q;
    assign mag_o   = MAG_W'({1'b0, re_sq_q}) + MAG_W'({1'b0, im_sq_q});

endmodule

// File: rtl/spectrum_peak_analyzer.sv
// spectrum_peak_analyzer: streaming per-frame peak-bin finder; SPA_SECOND_PEAK_EN adds second-peak outputs
module spectrum_peak_analyzer
    import spa_pkg::*;
#(
    parameter int N_BINS        = 16,
    parameter int DATA_W        = 16,
    parameter int SKIP_DC       = 0,
    parameter int HALF_SPECTRUM = 0,
    parameter int IDX_W         = spa_idx_w(N_BINS),
    parameter int MAG_W         = spa_mag_w(DATA_W)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     bin_valid,
    input  logic signed [DATA_W-1:0] bin_re,
    input  logic signed [DATA_W-1:0] bin_im,
    input  logic                     frame_abort,
`ifdef SPA_SECOND_PEAK_EN
    output logic [IDX_W-1:0]         freq2,
    output logic [MAG_W-1:0]         peak_mag2,
`endif
    output logic                     busy,
    output logic                     done,
    output logic [IDX_W-1:0]         freq,
    output logic [MAG_W-1:0]         peak_mag
);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(N_BINS - 1);

    spa_state_e       state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic             accept, flush, in_elig;
    logic             p_valid, p_elig, first, fin, have_e, upd;
    logic [IDX_W-1:0] p_idx;
    logic [MAG_W-1:0] p_mag;
    logic             have_q, have_d, done_q, done_d;
    logic [MAG_W-1:0] max_q, max_d, peak_q, peak_d;
    logic [IDX_W-1:0] midx_q, midx_d, freq_q, freq_d;
`ifdef SPA_SECOND_PEAK_EN
    logic             have2_q, have2_d, have2_e, beat2;
    logic [MAG_W-1:0] sec_q, sec_d, peak2_q, peak2_d;
    logic [IDX_W-1:0] sidx_q, sidx_d, freq2_q, freq2_d;
`endif

    // Abort always drops its beat; it only kills pipe contents while a frame is open,
    // so the last bin of an already-completed frame still reaches done
    assign accept  = bin_valid && !frame_abort;
    assign flush   = frame_abort && state_q == COLLECT;
    assign in_elig = spa_eligible(int'(cnt_q), N_BINS, SKIP_DC, HALF_SPECTRUM);

    spa_mag_pipe #(
        .DATA_W (DATA_W),
        .IDX_W  (IDX_W),
        .MAG_W  (MAG_W)
    ) u_pipe (
        .clk     (clk),
        .rst     (rst),
        .valid_i (accept),
        .flush_i (flush),
        .elig_i  (in_elig),
        .re_i    (bin_re),
        .im_i    (bin_im),
        .idx_i   (cnt_q),
        .valid_o (p_valid),
        .elig_o  (p_elig),
        .idx_o   (p_idx),
        .mag_o   (p_mag)
    );

    // Frame FSM state and bin counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: last beat closes the frame, so a following beat opens the next one gaplessly
    always_comb begin
        cnt_d   = frame_abort ? '0 : accept ? (cnt_q == LAST ? '0 : cnt_q + 1'b1) : cnt_q;
        state_d = frame_abort ? IDLE : accept ? (cnt_q == LAST ? IDLE : COLLECT) : state_q;
    end

    // FSM outputs
    always_comb begin
        busy = state_q == COLLECT;
    end

    // Running max; the per-frame reset keys off the pipelined index 0 so it cannot
    // disturb the previous frame's last bin still in the pipe
    always_comb begin
        first   = p_idx == '0;
        fin     = p_valid && p_idx == LAST;
        have_e  = first ? 1'b0 : have_q;
        upd     = p_valid && p_elig && (!have_e || p_mag > max_q);
        have_d  = p_valid ? (have_e || p_elig) : have_q;
        max_d   = upd ? p_mag : max_q;
        midx_d  = upd ? p_idx : midx_q;
        done_d  = fin;
        freq_d  = fin ? midx_d : freq_q;
        peak_d  = fin ? max_d : peak_q;
`ifdef SPA_SECOND_PEAK_EN
        have2_e = first ? 1'b0 : have2_q;
        beat2   = p_valid && p_elig && !upd && (!have2_e || p_mag > sec_q);
        sec_d   = (upd && have_e) ? max_q : beat2 ? p_mag : sec_q;
        sidx_d  = (upd && have_e) ? midx_q : beat2 ? p_idx : sidx_q;
        have2_d = p_valid ? (have2_e || (upd && have_e) || beat2) : have2_q;
        freq2_d = fin ? (have2_d ? sidx_d : '0) : freq2_q;
        peak2_d = fin ? (have2_d ? sec_d : '0) : peak2_q;
`endif
    end

    // Peak tracking state and result registers
    always_ff @(posedge clk) begin
        if (rst) begin
            have_q  <= 1'b0;
            max_q   <= '0;
            midx_q  <= '0;
            done_q  <= 1'b0;
            freq_q  <= '0;
            peak_q  <= '0;
`ifdef SPA_SECOND_PEAK_EN
            have2_q <= 1'b0;
            sec_q   <= '0;
            sidx_q  <= '0;
            freq2_q <= '0;
            peak2_q <= '0;
`endif
        end else begin
            have_q  <= have_d;
            max_q   <= max_d;
            midx_q  <= midx_d;
            done_q  <= done_d;
            freq_q  <= freq_d;
            peak_q  <= peak_d;
`ifdef SPA_SECOND_PEAK_EN
            have2_q <= have2_d;
            sec_q   <= sec_d;
            sidx_q  <= sidx_d;
            freq2_q <= freq2_d;
            peak2_q <= peak2_d;
`endif
        end
    end

    assign done     = done_q;
    assign freq     = freq_q;
    assign peak_mag = peak_q;
`ifdef SPA_SECOND_PEAK_EN
    assign freq2     = freq2_q;
    assign peak_mag2 = peak2_q;
`endif

endmodule

// File: tb/tb_spectrum_peak_analyzer.sv
// tb_spectrum_peak_analyzer: directed checks of the peak analyzer (default and half/skip-DC builds)
module tb_spectrum_peak_analyzer;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               bin_valid = 1'b0;
    logic               frame_abort = 1'b0;
    logic signed [15:0] bin_re = '0;
    logic signed [15:0] bin_im = '0;
    logic               a_busy, a_done, b_busy, b_done;
    logic [3:0]         a_freq, b_freq;
    logic [32:0]        a_peak, b_peak;
`ifdef SPA_SECOND_PEAK_EN
    logic [3:0]         a_freq2, b_freq2;
    logic [32:0]        a_peak2, b_peak2;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int fr_re[16];
    int fr_im[16];
    int cyc;
    int dn;
    int dcyc[2];
    logic [3:0]  dfreq[2];
    logic [32:0] dpk[2];

    always #5 clk = ~clk;

    spectrum_peak_analyzer dut_a (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_re(bin_re), .bin_im(bin_im),
        .frame_abort(frame_abort),
`ifdef SPA_SECOND_PEAK_EN
        .freq2(a_freq2), .peak_mag2(a_peak2),
`endif
        .busy(a_busy), .done(a_done), .freq(a_freq), .peak_mag(a_peak)
    );

    spectrum_peak_analyzer #(.SKIP_DC(1), .HALF_SPECTRUM(1)) dut_b (
        .clk(clk), .rst(rst), .bin_valid(bin_valid), .bin_re(bin_re), .bin_im(bin_im),
        .frame_abort(frame_abort),
`ifdef SPA_SECOND_PEAK_EN
        .freq2(b_freq2), .peak_mag2(b_peak2),
`endif
        .busy(b_busy), .done(b_done), .freq(b_freq), .peak_mag(b_peak)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input int re, input int im);
        bin_valid = v;
        bin_re = 16'(re);
        bin_im = 16'(im);
        step();
    endtask

    task automatic clear_frame();
        for (int i = 0; i < 16; i++) begin
            fr_re[i] = 0;
            fr_im[i] = 0;
        end
    endtask

    task automatic send_frame();
        for (int i = 0; i < 16; i++) drive(1'b1, fr_re[i], fr_im[i]);
        bin_valid = 1'b0;
    endtask

    task automatic observe();
        cyc++;
        if (a_done === 1'b1) begin
            if (dn < 2) begin
                dcyc[dn] = cyc;
                dfreq[dn] = a_freq;
                dpk[dn] = a_peak;
            end
            dn++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        step();
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %0d expected 0", a_busy); end
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL reset_done: got %0d expected 0", a_done); end
        n_cmp++; if (a_freq !== 4'd0) begin n_bad++; $display("FAIL reset_freq: got %0d expected 0", a_freq); end
        n_cmp++; if (a_peak !== 33'd0) begin n_bad++; $display("FAIL reset_peak: got %0d expected 0", a_peak); end
        n_cmp++; if (b_peak !== 33'd0) begin n_bad++; $display("FAIL reset_peak_b: got %0d expected 0", b_peak); end
    endtask

    task automatic test_single_peak();
        clear_frame();
        fr_re[5] = 300;
        fr_im[5] = -400;
        drive(1'b1, fr_re[0], fr_im[0]);
        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy: got %0d expected 1", a_busy); end
        for (int i = 1; i < 16; i++) drive(1'b1, fr_re[i], fr_im[i]);
        bin_valid = 1'b0;
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_end: got %0d expected 0", a_busy); end
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL single_done_early: got %0d expected 0", a_done); end
        step();
        n_cmp++; if (a_done !== 1'b1) begin n_bad++; $display("FAIL single_done: got %0d expected 1", a_done); end
        n_cmp++; if (a_freq !== 4'd5) begin n_bad++; $display("FAIL single_freq: got %0d expected 5", a_freq); end
        n_cmp++; if (a_peak !== 33'd250000) begin n_bad++; $display("FAIL single_peak: got %0d expected 250000", a_peak); end
        step();
        n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL single_done_pulse: got %0d expected 0", a_done); end
        n_cmp++; if (a_freq !== 4'd5) begin n_bad++; $display("FAIL single_freq_hold: got %0d expected 5", a_freq); end
    endtask

    task automatic test_tie();
        clear_frame();
        fr_re[3] = 100;
        fr_re[9] = 100;
        send_frame();
        step();
        n_cmp++; if (a_done !== 1'b1) begin n_bad++; $display("FAIL tie_done: got %0d expected 1", a_done); end
        n_cmp++; if (a_freq !== 4'd3) begin n_bad++; $display("FAIL tie_freq: got %0d expected 3", a_freq); end
        n_cmp++; if (a_peak !== 33'd10000) begin n_bad++; $display("FAIL tie_peak: got %0d expected 10000", a_peak); end
    endtask

    task automatic test_half_skip();
        clear_frame();
        fr_re[0] = 1000;
        fr_re[12] = 900;
        fr_re[2] = 10;
        fr_im[2] = 10;
        send_frame();
        step();
        n_cmp++; if (b_done !== 1'b1) begin n_bad++; $display("FAIL half_done: got %0d expected 1", b_done); end
        n_cmp++; if (b_freq !== 4'd2) begin n_bad++; $display("FAIL half_freq: got %0d expected 2", b_freq); end
        n_cmp++; if (b_peak !== 33'd200) begin n_bad++; $display("FAIL half_peak: got %0d expected 200", b_peak); end
        n_cmp++; if (a_freq !== 4'd0) begin n_bad++; $display("FAIL full_dc_freq: got %0d expected 0", a_freq); end
        n_cmp++; if (a_peak !== 33'd1000000) begin n_bad++; $display("FAIL full_dc_peak: got %0d expected 1000000", a_peak); end
    endtask

    task automatic test_back_to_back();
        cyc = 0;
        dn = 0;
        clear_frame();
        fr_re[7] = 50;
        for (int i = 0; i < 16; i++) begin
            drive(1'b1, fr_re[i], 0);
            observe();
        end
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                for (int g = 0; g < 3; g++) begin
                    drive(1'b0, 0, 0);
                    observe();
                    if (g == 2) begin
                        n_cmp++; if (a_busy !== 1'b1) begin n_bad++; $display("FAIL gap_busy: got %0d expected 1", a_busy); end
                    end
                end
            end
            drive(1'b1, (i == 1) ? 10 : 0, 0);
            observe();
        end
        bin_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            observe();
        end
        n_cmp++; if (dn !== 2) begin n_bad++; $display("FAIL b2b_count: got %0d expected 2", dn); end
        n_cmp++; if (dcyc[0] !== 17) begin n_bad++; $display("FAIL b2b_cyc0: got %0d expected 17", dcyc[0]); end
        n_cmp++; if (dfreq[0] !== 4'd7) begin n_bad++; $display("FAIL b2b_freq0: got %0d expected 7", dfreq[0]); end
        n_cmp++; if (dpk[0] !== 33'd2500) begin n_bad++; $display("FAIL b2b_peak0: got %0d expected 2500", dpk[0]); end
        n_cmp++; if (dcyc[1] !== 36) begin n_bad++; $display("FAIL b2b_cyc1: got %0d expected 36", dcyc[1]); end
        n_cmp++; if (dfreq[1] !== 4'd1) begin n_bad++; $display("FAIL b2b_freq1: got %0d expected 1", dfreq[1]); end
        n_cmp++; if (dpk[1] !== 33'd100) begin n_bad++; $display("FAIL b2b_peak1: got %0d expected 100", dpk[1]); end
    endtask

    task automatic test_abort();
        for (int i = 0; i < 8; i++) drive(1'b1, (i == 3) ? 200 : 0, 0);
        bin_valid = 1'b1;
        bin_re = 16'sd500;
        frame_abort = 1'b1;
        step();
        frame_abort = 1'b0;
        bin_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL abort_no_done: got %0d expected 0", a_done); end
            step();
        end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL abort_busy: got %0d expected 0", a_busy); end
        n_cmp++; if (a_freq !== 4'd1) begin n_bad++; $display("FAIL abort_freq_hold: got %0d expected 1", a_freq); end
        n_cmp++; if (a_peak !== 33'd100) begin n_bad++; $display("FAIL abort_peak_hold: got %0d expected 100", a_peak); end
        clear_frame();
        fr_re[10] = 7;
        fr_im[10] = -24;
        send_frame();
        step();
        n_cmp++; if (a_done !== 1'b1) begin n_bad++; $display("FAIL post_abort_done: got %0d expected 1", a_done); end
        n_cmp++; if (a_freq !== 4'd10) begin n_bad++; $display("FAIL post_abort_freq: got %0d expected 10", a_freq); end
        n_cmp++; if (a_peak !== 33'd625) begin n_bad++; $display("FAIL post_abort_peak: got %0d expected 625", a_peak); end
        clear_frame();
        fr_re[2] = 5;
        send_frame();
        frame_abort = 1'b1;
        step();
        frame_abort = 1'b0;
        n_cmp++; if (a_done !== 1'b1) begin n_bad++; $display("FAIL pending_done: got %0d expected 1", a_done); end
        n_cmp++; if (a_freq !== 4'd2) begin n_bad++; $display("FAIL pending_freq: got %0d expected 2", a_freq); end
        n_cmp++; if (a_peak !== 33'd25) begin n_bad++; $display("FAIL pending_peak: got %0d expected 25", a_peak); end
        for (int i = 0; i < 6; i++) drive(1'b1, (i == 4) ? 9 : 0, 0);
        bin_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            n_cmp++; if (a_done !== 1'b0) begin n_bad++; $display("FAIL rst_no_done: got %0d expected 0", a_done); end
            step();
        end
        n_cmp++; if (a_busy !== 1'b0) begin n_bad++; $display("FAIL rst_busy: got %0d expected 0", a_busy); end
        n_cmp++; if (a_freq !== 4'd0) begin n_bad++; $display("FAIL rst_freq: got %0d expected 0", a_freq); end
        n_cmp++; if (a_peak !== 33'd0) begin n_bad++; $display("FAIL rst_peak: got %0d expected 0", a_peak); end
        clear_frame();
        fr_re[6] = 3;
        fr_im[6] = 4;
        send_frame();
        step();
        n_cmp++; if (a_done !== 1'b1) begin n_bad++; $display("FAIL post_rst_done: got %0d expected 1", a_done); end
        n_cmp++; if (a_freq !== 4'd6) begin n_bad++; $display("FAIL post_rst_freq: got %0d expected 6", a_freq); end
        n_cmp++; if (a_peak !== 33'd25) begin n_bad++; $display("FAIL post_rst_peak: got %0d expected 25", a_peak); end
    endtask

    task automatic test_extreme();
        clear_frame();
        fr_re[4] = -32768;
        fr_im[4] = -32768;
        fr_re[9] = 1;
        fr_im[9] = 1;
        send_frame();
        step();
        n_cmp++; if (a_freq !== 4'd4) begin n_bad++; $display("FAIL ext_freq: got %0d expected 4", a_freq); end
        n_cmp++; if (a_peak !== 33'd2147483648) begin n_bad++; $display("FAIL ext_peak: got %0d expected 2147483648", a_peak); end
        n_cmp++; if (b_freq !== 4'd4) begin n_bad++; $display("FAIL ext_freq_b: got %0d expected 4", b_freq); end
        n_cmp++; if (b_peak !== 33'd2147483648) begin n_bad++; $display("FAIL ext_peak_b: got %0d expected 2147483648", b_peak); end
`ifdef SPA_SECOND_PEAK_EN
        n_cmp++; if (a_freq2 !== 4'd9) begin n_bad++; $display("FAIL ext_freq2: got %0d expected 9", a_freq2); end
        n_cmp++; if (a_peak2 !== 33'd2) begin n_bad++; $display("FAIL ext_peak2: got %0d expected 2", a_peak2); end
        n_cmp++; if (b_freq2 !== 4'd1) begin n_bad++; $display("FAIL ext_freq2_b: got %0d expected 1", b_freq2); end
        n_cmp++; if (b_peak2 !== 33'd0) begin n_bad++; $display("FAIL ext_peak2_b: got %0d expected 0", b_peak2); end
`endif
    endtask

    initial begin
        #1;
        test_reset();
        test_single_peak();
        test_tie();
        test_half_skip();
        test_back_to_back();
        test_abort();
        test_extreme();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
